// File: rtl/fifo_arb_pkg.sv
// Shared definitions for the FIFO write-port arbiter and the FIFO instance it feeds.
package fifo_arb_pkg;

  localparam int DATA_WIDTH       = 8;
  localparam int FIFO_DEPTH_WIDTH = 5;
  localparam int FIFO_DEPTH       = 1 << FIFO_DEPTH_WIDTH;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } arb_state_t;

  // Width needed to index 'value' items; never returns less than 1.
  function automatic int clog2(input int value);
    int w;
    w = 1;
    while ((1 << w) < value) w++;
    return w;
  endfunction

endpackage

// File: rtl/fifo_write_arbiter_rr_pick.sv
// Circular first-set search: lowest set request at or after i_rr_ptr, wrapping modulo NUM_REQ.
module rr_pick
  import fifo_arb_pkg::*;
#(
  parameter  int NUM_REQ = 4,
  localparam int IDX_W   = clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [IDX_W-1:0]   i_rr_ptr,
  output logic [IDX_W-1:0]   o_idx,
  output logic               o_any
);

  int w_cand;

  // NOTE: every output gets a default before the loop so no latch is inferred.
  always_comb begin
    o_idx  = '0;
    o_any  = |i_req;
    w_cand = 0;
    // Walk from the farthest offset down so the nearest hit is assigned last.
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      w_cand = int'(i_rr_ptr) + k;
      if (w_cand >= NUM_REQ) w_cand = w_cand - NUM_REQ;
      if (i_req[w_cand]) o_idx = IDX_W'(w_cand);
    end
  end

endmodule

// File: rtl/fifo_write_arbiter.sv
// Round-robin burst arbiter sharing one FIFO write port; every write is gated by full in the same cycle.
module fifo_write_arbiter #(
  parameter  int NUM_REQ    = 4,
  parameter  int DATA_WIDTH = fifo_arb_pkg::DATA_WIDTH,
  parameter  int MAX_BURST  = 8,
  localparam int IDX_W      = fifo_arb_pkg::clog2(NUM_REQ),
  localparam int CNT_W      = fifo_arb_pkg::clog2(MAX_BURST + 1)
) (
  input  logic                          clk_write,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] data_in,
  output logic [NUM_REQ-1:0]            ack,
  input  logic                          full,
  output logic                          write,
  output logic [DATA_WIDTH-1:0]         data_write,
  output logic [IDX_W-1:0]              owner,
  output logic                          busy
);

  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_REQ - 1);
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(MAX_BURST - 1);

  fifo_arb_pkg::arb_state_t r_state;
  logic [IDX_W-1:0]         r_owner;
  logic [IDX_W-1:0]         r_rr_ptr;
  logic [CNT_W-1:0]         r_beat_cnt;

  logic [IDX_W-1:0]         w_pick_idx;
  logic                     w_pick_any;
  logic                     w_owner_req;
  logic                     w_write;
  logic [IDX_W-1:0]         w_next_ptr;

  rr_pick #(
    .NUM_REQ (NUM_REQ)
  ) u_rr_pick (
    .i_req    (req),
    .i_rr_ptr (r_rr_ptr),
    .o_idx    (w_pick_idx),
    .o_any    (w_pick_any)
  );

  assign w_owner_req = req[r_owner];
  assign w_write     = (r_state == fifo_arb_pkg::BURST) && w_owner_req && !full;
  assign w_next_ptr  = (r_owner == LAST_IDX) ? '0 : r_owner + IDX_W'(1);

  assign write = w_write;
  assign owner = r_owner;
  assign busy  = (r_state == fifo_arb_pkg::BURST);

  always_comb begin
    ack        = '0;
    data_write = '0;
    if (w_write) begin
      ack[r_owner] = 1'b1;
      data_write   = data_in[int'(r_owner)*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register sees pre-edge values.
  always_ff @(posedge clk_write or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= fifo_arb_pkg::IDLE;
      r_owner    <= '0;
      r_rr_ptr   <= '0;
      r_beat_cnt <= '0;
    end else begin
      case (r_state)
        fifo_arb_pkg::IDLE: begin
          if (w_pick_any) begin
            r_owner    <= w_pick_idx;
            r_beat_cnt <= '0;
            r_state    <= fifo_arb_pkg::BURST;
          end
        end
        fifo_arb_pkg::BURST: begin
          // Release outranks full; a full FIFO only stalls the burst.
          if (!w_owner_req) begin
            r_state  <= fifo_arb_pkg::IDLE;
            r_rr_ptr <= w_next_ptr;
          end else if (!full) begin
            if (r_beat_cnt == LAST_BEAT) begin
              r_state  <= fifo_arb_pkg::IDLE;
              r_rr_ptr <= w_next_ptr;
            end else begin
              r_beat_cnt <= r_beat_cnt + CNT_W'(1);
            end
          end
        end
        default: r_state <= fifo_arb_pkg::IDLE;
      endcase
    end
  end

  a_no_write_when_full: assert property (@(posedge clk_write) disable iff (!rst_n) full |-> !write);
  a_ack_onehot0:        assert property (@(posedge clk_write) disable iff (!rst_n) $onehot0(ack));
  a_owner_range:        assert property (@(posedge clk_write) disable iff (!rst_n) int'(r_owner) < NUM_REQ);

endmodule

// File: doc/fifo_write_arbiter.md
Name: fifo_write_arbiter

Overview:
Round-robin arbiter that shares the single write port of the async FIFO (32x8 configuration) among NUM_REQ producers in the write clock domain. Each producer uses a valid/ack handshake. The arbiter grants the port in bursts of up to MAX_BURST words and gates every write with the FIFO full flag in the same cycle, so the FIFO can never overflow. It sits directly in front of the FIFO write side and has no read-domain logic.

Parameters:
NUM_REQ, 4, number of producers (2..8; non-power-of-2 allowed)
DATA_WIDTH, 8, word width; must match the FIFO DATA_WIDTH
MAX_BURST, 8, maximum words per grant before the port is re-arbitrated (1..16)

Ports:
clk_write  in  1  write-domain clock; the same clock that drives the FIFO write side
rst_n  in  1  reset
req  in  NUM_REQ  per-producer valid; word is present on its data slice
data_in  in  NUM_REQ*DATA_WIDTH  flattened producer data; slice i is [i*DATA_WIDTH +: DATA_WIDTH]
ack  out  NUM_REQ  one-hot; ack[i]=1 means the word from producer i is written this cycle
full  in  1  FIFO full flag (write domain)
write  out  1  FIFO write enable
data_write  out  DATA_WIDTH  FIFO write data
owner  out  clog2(NUM_REQ)  current grant holder; meaningful only while busy=1
busy  out  1  1 in the BURST state

Interface (already decided): single clock, clk_write. Reset rst_n is asynchronous and active-low.

Behaviour:
- Reset (rst_n=0, asynchronous): state=IDLE, rr_ptr=0, owner=0, beat_cnt=0. While in reset: write=0, ack=0, busy=0, data_write=0.
- Registered state: state, owner, rr_ptr, beat_cnt (clog2(MAX_BURST+1) bits).
- Combinational outputs: write, ack, data_write.
  - write = (state==BURST) & req[owner] & ~full.
  - ack[i] = write & (owner==i).
  - data_write = data_in slice[owner] when write=1, else 0.
- State IDLE:
  - No write.
  - If any req bit is set: owner <= first set req in circular order starting at rr_ptr; beat_cnt <= 0; go to BURST.
  - Otherwise stay in IDLE.
  - This costs one arbitration bubble cycle per grant.
- State BURST, evaluated each cycle in this priority order:
  - req[owner]=0: go to IDLE, rr_ptr <= (owner+1) mod NUM_REQ, no write. This is a voluntary release or abort.
  - full=1: stall. No write, no ack, beat_cnt held, grant kept. A full FIFO never ends a burst.
  - Write accepted and beat_cnt==MAX_BURST-1: go to IDLE, rr_ptr <= (owner+1) mod NUM_REQ.
  - Write accepted otherwise: beat_cnt <= beat_cnt+1.
- Throughput: a continuous requester achieves MAX_BURST words per MAX_BURST+1 cycles when the FIFO is not full.
- Producer contract:
  - Hold req and data stable until ack.
  - Change data on the cycle after ack, or drop req then.
  - Dropping req before ack is legal (abort); no word is written.
- Fairness: round-robin over grants. With k active producers, each waits at most (k-1)*(MAX_BURST+1) non-full cycles for a grant.
- Wrap: rr_ptr and the owner search wrap modulo NUM_REQ, including when NUM_REQ is not a power of 2.
- Simultaneous events:
  - full rising in the same cycle as the last beat: no write, burst not complete, grant retained.
  - full=1 and req[owner] falling in the same cycle: release takes priority.
- Reset mid-burst: immediate return to IDLE with rr_ptr=0. A word without ack is not written.
- Assertions: write=0 whenever full=1; ack is one-hot or zero; owner < NUM_REQ.

Decomposition:
- Shared package fifo_arb_pkg holds:
  - state enum {IDLE, BURST};
  - clog2 helper function;
  - default constants DATA_WIDTH=8 and FIFO_DEPTH_WIDTH=5, shared with the FIFO instance.
- One natural sub-module, rr_pick: combinational circular first-set search. Inputs are req and rr_ptr; outputs are idx and any.

Test Plan:
- Single producer: req[2]=1 with data 0x00..0x09, full=0 -> first write 1 cycle after req; words 0x00-0x07 on 8 consecutive cycles; 1 bubble; 0x08-0x09 follow; FIFO reads back 0x00..0x09 in order.
- All 4 producers requesting continuously from reset -> grant order 0,1,2,3,0; each burst is exactly 8 acks; busy=0 for exactly 1 cycle between bursts.
- Full backpressure: producer 0 active, full forced high after 3 words for 5 cycles -> write=0 and ack=0 for all 5 cycles; owner stays 0; remaining 5 words complete after full drops; total 8.
- Abort: req[1] dropped after 2 acks while req[3]=1 -> IDLE next cycle; rr_ptr=2; producer 3 granted; producer 1's 3rd word never written.
- Real FIFO attached (32x8, write 100 MHz, read 13 MHz), 2 producers each pushing 40 words, reader draining continuously -> full asserts, no overflow, all 80 words read exactly once, per-producer order preserved.
- Reset asserted mid-burst after 4 beats -> write, ack and busy are 0 immediately (asynchronous); after release, first grant goes to the lowest active index from rr_ptr=0.
